// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the iterative multiply/divide units, with a hang watchdog.
// Optional: define MULTDIV_ZERO_FASTPATH_EN to complete divide-by-zero without launching the divider.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        flush,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_ready,
  input  logic [31:0] mult_result,
  input  logic        mult_exc,
  input  logic        div_ready,
  input  logic [31:0] div_result,
  input  logic        div_exc,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_rdy,
  output logic        result_exc
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

  localparam logic [5:0] TimeoutC = TIMEOUT[5:0];

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] unitA_q, unitA_d;
  logic [31:0] unitB_q, unitB_d;
  logic [5:0]  waitCnt_q, waitCnt_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic        request;
  logic        zeroFast;
  logic        selReady;
  logic [31:0] selResult;
  logic        selExc;
  logic        timedOut;

  assign request = ctrl_mult | ctrl_div;

`ifdef MULTDIV_ZERO_FASTPATH_EN
  assign zeroFast = ctrl_div & ~ctrl_mult & (data_b == 32'd0);
`else
  assign zeroFast = 1'b0;
`endif

  // Only the unit that was launched is listened to; the other may toggle freely.
  assign selReady  = op_q ? div_ready  : mult_ready;
  assign selResult = op_q ? div_result : mult_result;
  assign selExc    = op_q ? div_exc    : mult_exc;
  assign timedOut  = (waitCnt_q == TimeoutC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          state_d = zeroFast ? DONE : START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (selReady || timedOut) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a ready arriving in the same cycle.
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    op_d      = op_q;
    unitA_d   = unitA_q;
    unitB_d   = unitB_q;
    waitCnt_d = waitCnt_q;
    result_d  = result_q;
    exc_d     = exc_q;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (request) begin
            unitA_d = data_a;
            unitB_d = data_b;
            op_d    = ~ctrl_mult;
            if (zeroFast) begin
              result_d = 32'd0;
              exc_d    = 1'b1;
            end
          end
        end
        START: waitCnt_d = 6'd0;
        WAIT: begin
          if (selReady) begin
            result_d = selResult;
            exc_d    = selExc;
          end else if (timedOut) begin
            result_d = 32'd0;
            exc_d    = 1'b1;
          end else begin
            waitCnt_d = waitCnt_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 1'b0;
      unitA_q   <= 32'd0;
      unitB_q   <= 32'd0;
      waitCnt_q <= 6'd0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      unitA_q   <= unitA_d;
      unitB_q   <= unitB_d;
      waitCnt_q <= waitCnt_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
    end
  end

  always_comb begin
    mult_start = 1'b0;
    div_start  = 1'b0;
    stall      = 1'b0;
    result_rdy = 1'b0;
    case (state_q)
      IDLE: stall = request;
      START: begin
        stall      = 1'b1;
        mult_start = ~op_q;
        div_start  = op_q;
      end
      WAIT:    stall = 1'b1;
      DONE:    result_rdy = 1'b1;
      default: ;
    endcase
  end

  assign unit_a     = unitA_q;
  assign unit_b     = unitB_q;
  assign result     = result_q;
  assign result_exc = exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a vector table run back-to-back plus flush and reset sequences.
module tb_multdiv_ctrl;

  localparam int Timeout = 40;

  logic        clk;
  logic        reset;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        flush;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        mult_start;
  logic        div_start;
  logic        mult_ready;
  logic [31:0] mult_result;
  logic        mult_exc;
  logic        div_ready;
  logic [31:0] div_result;
  logic        div_exc;
  logic        stall;
  logic [31:0] result;
  logic        result_rdy;
  logic        result_exc;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl #(.TIMEOUT(Timeout)) dut (
    .clk(clk),
    .reset(reset),
    .ctrl_mult(ctrl_mult),
    .ctrl_div(ctrl_div),
    .data_a(data_a),
    .data_b(data_b),
    .flush(flush),
    .unit_a(unit_a),
    .unit_b(unit_b),
    .mult_start(mult_start),
    .div_start(div_start),
    .mult_ready(mult_ready),
    .mult_result(mult_result),
    .mult_exc(mult_exc),
    .div_ready(div_ready),
    .div_result(div_result),
    .div_exc(div_exc),
    .stall(stall),
    .result(result),
    .result_rdy(result_rdy),
    .result_exc(result_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation: request, unit behaviour, and what the pipeline must see.
  // delay is cycles from the start pulse to the unit's ready; -1 means never.
  typedef struct {
    string       name;
    logic        reqMult;
    logic        reqDiv;
    logic [31:0] a;
    logic [31:0] b;
    int          delay;
    logic [31:0] unitRes;
    logic        unitExc;
    logic        startNoise;
    logic        otherNoise;
    logic [31:0] expRes;
    logic        expExc;
    int          expMultStarts;
    int          expDivStarts;
    int          expRdyCycle;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idleUnits();
    mult_ready  = 1'b0;
    mult_result = 32'hDEADBEEF;
    mult_exc    = 1'b0;
    div_ready   = 1'b0;
    div_result  = 32'hDEADBEEF;
    div_exc     = 1'b0;
  endtask

  // Drives one request starting in the next IDLE cycle and models the unit cycle by cycle.
  // Cycle 0 is the request cycle; returns after sampling the result_rdy cycle.
  task automatic applyStimulus(input vec_t v);
    int          rdyCycle = -1;
    int          ms = 0;
    int          ds = 0;
    int          stallErr = 0;
    int          holdErr = 0;
    int          startErr = 0;
    logic [31:0] gotRes = 32'hx;
    logic        gotExc = 1'bx;
    logic        rdyAtReq = 1'b0;
    logic        selDiv;
    selDiv = ~v.reqMult & v.reqDiv;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      ctrl_mult = (c == 0) ? v.reqMult : 1'b0;
      ctrl_div  = (c == 0) ? v.reqDiv : 1'b0;
      data_a    = (c == 0) ? v.a : 32'h5A5A5A5A;
      data_b    = (c == 0) ? v.b : 32'hA5A5A5A5;
      idleUnits();
      if (v.otherNoise && c >= 1) begin
        if (selDiv) begin
          mult_ready = 1'b1; mult_result = 32'hBAD0BAD0; mult_exc = 1'b1;
        end else begin
          div_ready = 1'b1; div_result = 32'hBAD0BAD0; div_exc = 1'b1;
        end
      end
      if ((v.startNoise && c == 1) || (v.delay >= 0 && c == 1 + v.delay)) begin
        if (selDiv) begin
          div_ready  = 1'b1;
          div_result = (c == 1 + v.delay) ? v.unitRes : 32'h0BAD0BAD;
          div_exc    = (c == 1 + v.delay) ? v.unitExc : 1'b1;
        end else begin
          mult_ready  = 1'b1;
          mult_result = (c == 1 + v.delay) ? v.unitRes : 32'h0BAD0BAD;
          mult_exc    = (c == 1 + v.delay) ? v.unitExc : 1'b1;
        end
      end
      @(negedge clk);
      if (c == 0) rdyAtReq = result_rdy;
      if (mult_start) begin ms++; if (c != 1) startErr++; end
      if (div_start) begin ds++; if (c != 1) startErr++; end
      if (result_rdy) begin
        rdyCycle = c;
        gotRes   = result;
        gotExc   = result_exc;
        if (stall !== 1'b0) stallErr++;
        break;
      end
      if (stall !== 1'b1) stallErr++;
      if (c >= 1 && (unit_a !== v.a || unit_b !== v.b)) holdErr++;
    end
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    checkOutput({v.name, " rdy_low_at_request"}, 32'(rdyAtReq), 32'd0);
    checkOutput({v.name, " mult_start_count"}, 32'(ms), 32'(v.expMultStarts));
    checkOutput({v.name, " div_start_count"}, 32'(ds), 32'(v.expDivStarts));
    checkOutput({v.name, " start_off_cycle1"}, 32'(startErr), 32'd0);
    checkOutput({v.name, " rdy_cycle"}, 32'(rdyCycle), 32'(v.expRdyCycle));
    checkOutput({v.name, " result"}, gotRes, v.expRes);
    checkOutput({v.name, " result_exc"}, 32'(gotExc), 32'(v.expExc));
    checkOutput({v.name, " stall_errors"}, 32'(stallErr), 32'd0);
    checkOutput({v.name, " operand_hold_errors"}, 32'(holdErr), 32'd0);
  endtask

  initial begin
    logic [31:0] lastRes;
    logic        lastExc;
    int          lateErr;

    // name, mult, div, a, b, delay, unitRes, unitExc, startNoise, otherNoise,
    // expRes, expExc, multStarts, divStarts, rdyCycle
    vecs[0] = '{"mul_6x7", 1'b1, 1'b0, 32'd6, 32'd7, 32, 32'd42, 1'b0, 1'b0, 1'b0,
                32'd42, 1'b0, 1, 0, 34};
    vecs[1] = '{"div_m100_7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 10, 32'hFFFFFFF2, 1'b0, 1'b0, 1'b0,
                32'hFFFFFFF2, 1'b0, 0, 1, 12};
`ifdef MULTDIV_ZERO_FASTPATH_EN
    vecs[2] = '{"div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, -1, 32'd0, 1'b0, 1'b0, 1'b0,
                32'd0, 1'b1, 0, 0, 1};
`else
    vecs[2] = '{"div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, 5, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0,
                32'hFFFFFFFF, 1'b1, 0, 1, 7};
`endif
    vecs[3] = '{"timeout", 1'b1, 1'b0, 32'd3, 32'd5, -1, 32'd0, 1'b0, 1'b0, 1'b0,
                32'd0, 1'b1, 1, 0, Timeout + 3};
    vecs[4] = '{"both_req", 1'b1, 1'b1, 32'd8, 32'd9, 3, 32'd72, 1'b0, 1'b0, 1'b0,
                32'd72, 1'b0, 1, 0, 5};
    vecs[5] = '{"ready_in_start", 1'b1, 1'b0, 32'h00010000, 32'h00010000, 1, 32'd0, 1'b1, 1'b1, 1'b0,
                32'd0, 1'b1, 1, 0, 3};
    vecs[6] = '{"other_unit_noise", 1'b0, 1'b1, 32'd50, 32'd5, 4, 32'd10, 1'b0, 1'b0, 1'b1,
                32'd10, 1'b0, 0, 1, 6};
    vecs[7] = '{"ready_last_wait", 1'b1, 1'b0, 32'd2, 32'd2, Timeout + 1, 32'd4, 1'b0, 1'b0, 1'b0,
                32'd4, 1'b0, 1, 0, Timeout + 3};

    reset     = 1'b1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    data_a    = 32'd0;
    data_b    = 32'd0;
    flush     = 1'b0;
    idleUnits();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset result_exc", 32'(result_exc), 32'd0);
    checkOutput("reset result_rdy", 32'(result_rdy), 32'd0);
    checkOutput("reset starts", 32'({mult_start, div_start}), 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset unit_a", unit_a, 32'd0);
    checkOutput("reset unit_b", unit_b, 32'd0);

    // Each vector is requested in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end
    lastRes = vecs[7].expRes;
    lastExc = vecs[7].expExc;

    // Flush during WAIT (cycle 5), then a late ready that must be ignored.
    @(posedge clk);
    #1;
    idleUnits();
    ctrl_mult = 1'b1;
    data_a    = 32'd3;
    data_b    = 32'd4;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      ctrl_mult = 1'b0;
      data_a    = 32'h5A5A5A5A;
      data_b    = 32'hA5A5A5A5;
      flush     = (c == 5);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush stall", 32'(stall), 32'd0);
    checkOutput("flush result_rdy", 32'(result_rdy), 32'd0);
    checkOutput("flush result kept", result, lastRes);
    checkOutput("flush result_exc kept", 32'(result_exc), 32'(lastExc));
    lateErr = 0;
    for (int c = 7; c <= 12; c++) begin
      @(posedge clk);
      #1;
      mult_ready  = (c == 7);
      mult_result = 32'd99;
      mult_exc    = (c == 7);
      @(negedge clk);
      if (result_rdy || mult_start || div_start || stall) lateErr++;
      if (result !== lastRes || result_exc !== lastExc) lateErr++;
    end
    checkOutput("flush late_ready_ignored", 32'(lateErr), 32'd0);

    // Reset mid-operation drops the operation and clears the result registers.
    @(posedge clk);
    #1;
    idleUnits();
    ctrl_mult = 1'b1;
    data_a    = 32'd11;
    data_b    = 32'd12;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      ctrl_mult = 1'b0;
      reset     = (c == 4);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset result", result, 32'd0);
    checkOutput("midreset result_exc", 32'(result_exc), 32'd0);
    checkOutput("midreset stall", 32'(stall), 32'd0);
    checkOutput("midreset result_rdy", 32'(result_rdy), 32'd0);
    checkOutput("midreset unit_a", unit_a, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
